// File: rtl/dpr_pkg.sv
// Shared sizing and types for the 16x4 distributed dual-port RAM.
package dpr_pkg;

  localparam int DPR_DATA_W = 4;
  localparam int DPR_ADDR_W = 4;
  localparam int DPR_DEPTH  = 16;

  typedef logic [DPR_DATA_W-1:0] dpr_word_t;
  typedef logic [DPR_ADDR_W-1:0] dpr_addr_t;

endpackage

// File: rtl/dpr_word.sv
// One storage word of the distributed RAM: async active-low clear,
// loads d on a rising clk when its decoded write enable is high.
module dpr_word
  import dpr_pkg::*;
#(
  parameter int                DATA_W  = DPR_DATA_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  // Word register; reset overrides any pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dpr16x4_ram.sv
// 16x4 distributed dual-port RAM: synchronous write port, combinational
// read port. Define DPR16X4_BYPASS_EN to make write data visible on the
// read port before the edge when rad == wad (write-through bypass).
module dpr16x4_ram
  import dpr_pkg::*;
#(
  parameter int                DATA_W  = DPR_DATA_W,
  parameter int                ADDR_W  = DPR_ADDR_W,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wre,
  input  logic [ADDR_W-1:0] wad,
  input  logic [DATA_W-1:0] di,
  input  logic [ADDR_W-1:0] rad,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    logic we_word;
    assign we_word = wre && (wad == ADDR_W'(g));

    dpr_word #(
      .DATA_W  (DATA_W),
      .RST_VAL (RST_VAL)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .we  (we_word),
      .d   (di),
      .q   (mem[g])
    );
  end

`ifdef DPR16X4_BYPASS_EN
  // Read mux with write-through: pending write data wins on an address match.
  always_comb begin
    dout = mem[rad];
    if (rst && wre && (rad == wad)) begin
      dout = di;
    end
  end
`else
  // Plain read mux; a colliding write shows up only after the edge.
  always_comb begin
    dout = mem[rad];
  end
`endif

endmodule

// File: tb/tb_dpr16x4_ram.sv
// Self-checking bench for dpr16x4_ram (works with or without DPR16X4_BYPASS_EN).
module tb_dpr16x4_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wre = 1'b0;
  logic [3:0] wad = '0;
  logic [3:0] di  = '0;
  logic [3:0] rad = '0;
  logic [3:0] dout;

  dpr16x4_ram dut (
    .clk  (clk),
    .rst  (rst),
    .wre  (wre),
    .wad  (wad),
    .di   (di),
    .rad  (rad),
    .dout (dout)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [3:0] wad;
    logic [3:0] di;
    logic [3:0] rad;
    logic [3:0] exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  string      name_q[$];
  logic [3:0] model[16];

  // Drive read address, queue the expectation, then compare shortly after.
  task automatic check_rd(input logic [3:0] a, input logic [3:0] e, input string nm);
    logic [3:0] ex;
    string      n;
    rad = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      ex = exp_q.pop_front();
      n  = name_q.pop_front();
      if (dout !== ex) begin
        errors++;
        $display("FAIL %s rad=%0d: got %h required %h", n, a, dout, ex);
      end
    end
  endtask

  // One write cycle, inputs changed on the falling edge.
  task automatic wr(input logic w, input logic [3:0] a, input logic [3:0] d);
    @(negedge clk);
    wre = w;
    wad = a;
    di  = d;
    @(posedge clk);
    #1;
    wre = 1'b0;
    if (w && rst) model[a] = d;
  endtask

  initial begin
    vec_t       vec[16];
    logic [3:0] pat[16] = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hE, 4'hF, 4'hC, 4'hD,
                            4'h2, 4'h3, 4'h0, 4'h1, 4'h6, 4'h7, 4'h4, 4'h5};
    for (int i = 0; i < 16; i++) begin
      vec[i] = '{wad: 4'(i), di: pat[i], rad: 4'(i), exp: pat[i]};
      model[i] = 4'h0;
    end

    // Reset state at time zero, before any clock edge
    check_rd(4'd0, 4'h0, "rst_init");
    check_rd(4'd5, 4'h0, "rst_init");
    check_rd(4'd15, 4'h0, "rst_init");

    @(negedge clk);
    rst = 1'b1;

    // Test 1: random writes, then async clear sweep
    for (int i = 0; i < 8; i++) begin
      wr(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 4'h0;
    for (int i = 0; i < 16; i++) check_rd(4'(i), 4'h0, "rst_clear");
    @(negedge clk);
    rst = 1'b1;

    // Test 2: table-driven write/readback
    for (int i = 0; i < 16; i++) wr(1'b1, vec[i].wad, vec[i].di);
    for (int i = 0; i < 16; i++) check_rd(vec[i].rad, vec[i].exp, "readback");

    // Test 3: write enable gating
    for (int i = 0; i < 4; i++) wr(1'b0, 4'd3, 4'hF);
    check_rd(4'd3, 4'h9, "wre_gate");
    wr(1'b1, 4'd3, 4'hF);
    check_rd(4'd3, 4'hF, "wre_write");
    check_rd(4'd2, 4'h8, "wre_neighbor");
    check_rd(4'd4, 4'hE, "wre_neighbor");

    // Test 4: independent ports
    @(negedge clk);
    rad = 4'd7;
    wad = 4'd2;
    di  = 4'h5;
    wre = 1'b1;
    check_rd(4'd7, 4'hD, "indep_pre");
    @(posedge clk);
    #1;
    wre = 1'b0;
    model[2] = 4'h5;
    check_rd(4'd7, 4'hD, "indep_post");
    check_rd(4'd2, 4'h5, "indep_rad_change");

    // Test 5: read/write collision
    wr(1'b1, 4'd6, 4'h1);
    @(negedge clk);
    wad = 4'd6;
    di  = 4'hC;
    wre = 1'b1;
`ifdef DPR16X4_BYPASS_EN
    check_rd(4'd6, 4'hC, "collide_pre");
`else
    check_rd(4'd6, 4'h1, "collide_pre");
`endif
    @(posedge clk);
    #1;
    wre = 1'b0;
    check_rd(4'd6, 4'hC, "collide_post");

    // Test 6: async reset in the middle of a pending write
    @(negedge clk);
    wad = 4'd4;
    di  = 4'h7;
    wre = 1'b1;
`ifdef DPR16X4_BYPASS_EN
    check_rd(4'd4, 4'h7, "rstmid_pre");
`else
    check_rd(4'd4, 4'hE, "rstmid_pre");
`endif
    #2;
    rst = 1'b0;
    check_rd(4'd4, 4'h0, "rstmid_async");
    check_rd(4'd5, 4'h0, "rstmid_async");
    check_rd(4'd4, 4'h0, "rstmid_async");
    @(posedge clk);
    #1;
    check_rd(4'd4, 4'h0, "rstmid_suppress");
    @(negedge clk);
    rst = 1'b1;
`ifdef DPR16X4_BYPASS_EN
    check_rd(4'd4, 4'h7, "rstmid_release");
`else
    check_rd(4'd4, 4'h0, "rstmid_release");
`endif
    @(posedge clk);
    #1;
    wre = 1'b0;
    check_rd(4'd4, 4'h7, "rstmid_resume");
    check_rd(4'd5, 4'h0, "rstmid_other");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
